// File: rtl/depp_pkg.sv
// Shared types and constants for the DEPP register-file slave.
package depp_pkg;

    localparam int unsigned DEPP_DW = 8;
    localparam logic [DEPP_DW-1:0] RD_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_WR,
        ADDR_RD,
        DATA_WR,
        DATA_RD,
        ACK
    } depp_state_e;

endpackage

// File: rtl/depp_sync.sv
// N-stage flip-flop synchroniser with a configurable reset value per bit.
module depp_sync #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) stg[i] <= RST_VAL;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/depp_regfile.sv
// EPP slave with oversampled host strobes, wait handshake FSM and an
// 8-bit register file with read-only status slots and access strobes.
module depp_regfile
    import depp_pkg::*;
#(
    parameter int unsigned         NUM_REGS    = 16,
    parameter int unsigned         SYNC_STAGES = 2,
    parameter int unsigned         AUTO_INC    = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_astb,
    input  logic                        a_dstb,
    input  logic                        a_write,
    input  logic [DEPP_DW-1:0]          a_db_i,
    output logic [DEPP_DW-1:0]          a_db_o,
    output logic                        a_db_oe,
    output logic                        a_wait,
    output logic [DEPP_DW-1:0]          addr_reg,
    output logic [NUM_REGS*DEPP_DW-1:0] regs_o,
    input  logic [NUM_REGS*DEPP_DW-1:0] status_in,
    output logic                        wr_stb,
    output logic                        rd_stb,
    output logic [DEPP_DW-1:0]          acc_addr,
    output logic [DEPP_DW-1:0]          wr_data
);

    logic [2:0]         s_ctl;
    logic               s_astb, s_dstb, s_write;
    logic [DEPP_DW-1:0] s_db;

    // Strobes and write idle high so reset never looks like a host cycle.
    depp_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111)) u_sync_ctl (
        .clk (clk),
        .rst (rst),
        .d   ({a_astb, a_dstb, a_write}),
        .q   (s_ctl)
    );

    depp_sync #(.WIDTH(DEPP_DW), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_db (
        .clk (clk),
        .rst (rst),
        .d   (a_db_i),
        .q   (s_db)
    );

    assign {s_astb, s_dstb, s_write} = s_ctl;

    depp_state_e        state, state_nx;
    logic               cyc_data, cyc_data_nx;
    logic               wait_nx, oe_nx, wr_stb_nx, rd_stb_nx, reg_we;
    logic [DEPP_DW-1:0] dbo_nx, addr_nx, acc_nx, wrd_nx, rd_val;

    // Read mux: status for read-only slots, storage otherwise, default out of range.
    always_comb begin
        rd_val = RD_DEFAULT;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (addr_reg == 8'(i)) begin
                rd_val = RO_MASK[i] ? status_in[i*DEPP_DW +: DEPP_DW]
                                    : regs_o[i*DEPP_DW +: DEPP_DW];
            end
        end
    end

    // Read data and strobes are loaded on entry to the action state so they
    // lead a_wait by one cycle.
    always_comb begin
        state_nx    = state;
        cyc_data_nx = cyc_data;
        wait_nx     = a_wait;
        oe_nx       = a_db_oe;
        dbo_nx      = a_db_o;
        addr_nx     = addr_reg;
        acc_nx      = acc_addr;
        wrd_nx      = wr_data;
        wr_stb_nx   = 1'b0;
        rd_stb_nx   = 1'b0;
        reg_we      = 1'b0;
        case (state)
            IDLE: begin
                if (!s_astb) begin
                    cyc_data_nx = 1'b0;
                    if (!s_write) begin
                        state_nx = ADDR_WR;
                    end else begin
                        state_nx = ADDR_RD;
                        dbo_nx   = addr_reg;
                        oe_nx    = 1'b1;
                    end
                end else if (!s_dstb) begin
                    cyc_data_nx = 1'b1;
                    acc_nx      = addr_reg;
                    if (!s_write) begin
                        state_nx  = DATA_WR;
                        wr_stb_nx = 1'b1;
                        wrd_nx    = s_db;
                    end else begin
                        state_nx  = DATA_RD;
                        rd_stb_nx = 1'b1;
                        dbo_nx    = rd_val;
                        oe_nx     = 1'b1;
                    end
                end
            end
            ADDR_WR: begin
                addr_nx  = s_db;
                state_nx = ACK;
                wait_nx  = 1'b1;
            end
            ADDR_RD: begin
                state_nx = ACK;
                wait_nx  = 1'b1;
            end
            DATA_WR: begin
                reg_we   = 1'b1;
                state_nx = ACK;
                wait_nx  = 1'b1;
            end
            DATA_RD: begin
                state_nx = ACK;
                wait_nx  = 1'b1;
            end
            ACK: begin
                if (cyc_data ? s_dstb : s_astb) begin
                    state_nx = IDLE;
                    wait_nx  = 1'b0;
                    oe_nx    = 1'b0;
                    if (cyc_data && AUTO_INC != 0) addr_nx = addr_reg + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cyc_data <= 1'b0;
            a_wait   <= 1'b0;
            a_db_oe  <= 1'b0;
            a_db_o   <= '0;
            addr_reg <= '0;
            wr_stb   <= 1'b0;
            rd_stb   <= 1'b0;
            acc_addr <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_nx;
            cyc_data <= cyc_data_nx;
            a_wait   <= wait_nx;
            a_db_oe  <= oe_nx;
            a_db_o   <= dbo_nx;
            addr_reg <= addr_nx;
            wr_stb   <= wr_stb_nx;
            rd_stb   <= rd_stb_nx;
            acc_addr <= acc_nx;
            wr_data  <= wrd_nx;
        end
    end

    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
        logic [DEPP_DW-1:0] r;

        always_ff @(posedge clk) begin
            if (rst) begin
                r <= '0;
            end else if (reg_we && addr_reg == 8'(i) && !RO_MASK[i]) begin
                r <= s_db;
            end
        end

        assign regs_o[i*DEPP_DW +: DEPP_DW] = r;
    end

endmodule

// File: tb/tb_depp_regfile.sv
// Randomised host-cycle bench for depp_regfile against an array-based model
// of the register file, address pointer and handshake timing.
module tb_depp_regfile;

    localparam int unsigned NR = 16;
    localparam int unsigned SS = 2;
    localparam logic [NR-1:0] RO = 16'h0020;

    logic           clk, rst, a_astb, a_dstb, a_write, a_db_oe, a_wait, wr_stb, rd_stb;
    logic [7:0]     a_db_i, a_db_o, addr_reg, acc_addr, wr_data;
    logic [NR*8-1:0] regs_o, status_in;

    depp_regfile #(
        .NUM_REGS(NR), .SYNC_STAGES(SS), .AUTO_INC(1), .RO_MASK(RO)
    ) dut (
        .clk(clk), .rst(rst), .a_astb(a_astb), .a_dstb(a_dstb), .a_write(a_write),
        .a_db_i(a_db_i), .a_db_o(a_db_o), .a_db_oe(a_db_oe), .a_wait(a_wait),
        .addr_reg(addr_reg), .regs_o(regs_o), .status_in(status_in),
        .wr_stb(wr_stb), .rd_stb(rd_stb), .acc_addr(acc_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state
    logic [7:0] m_regs [NR];
    logic [7:0] m_addr;

    function automatic logic [127:0] m_flat();
        logic [127:0] f = '0;
        for (int i = 0; i < int'(NR); i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    function automatic logic [7:0] m_rdval(input logic [7:0] a);
        int ai = int'(a);
        if (ai >= int'(NR)) return 8'h00;
        if (RO[ai]) return status_in[ai*8 +: 8];
        return m_regs[ai];
    endfunction

    // Strobe monitor, sampled mid-cycle
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [7:0] mon_acc = '0;
    logic [7:0] mon_wd = '0;
    always @(negedge clk) begin
        if (wr_stb) begin wr_cnt++; mon_acc = acc_addr; mon_wd = wr_data; end
        if (rd_stb) begin rd_cnt++; mon_acc = acc_addr; end
    end

    task automatic host(input bit is_addr, input bit is_wr, input logic [7:0] d, input bit wiggle);
        int n, w0, r0;
        logic [7:0] exp_rd, a_before, dbo_pre;
        logic oe_pre;
        a_before = m_addr;
        exp_rd   = is_addr ? m_addr : m_rdval(m_addr);
        w0 = wr_cnt;
        r0 = rd_cnt;
        @(negedge clk);
        a_write = !is_wr;
        a_db_i  = d;
        if (is_addr) a_astb = 1'b0; else a_dstb = 1'b0;
        n = 0; oe_pre = 1'b0; dbo_pre = '0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (a_wait) break;
            oe_pre  = a_db_oe;
            dbo_pre = a_db_o;
        end
        check("wait_rise_lat", n, SS + 2);
        if (!is_wr) begin
            check("oe_before_wait", oe_pre, 1);
            check("dbo_before_wait", dbo_pre, exp_rd);
            check("dbo_in_ack", a_db_o, exp_rd);
        end else begin
            check("oe_on_write", a_db_oe, 0);
        end
        if (wiggle) a_write = $urandom_range(0, 1);
        if (is_addr && is_wr) m_addr = d;
        if (!is_addr && is_wr && int'(m_addr) < int'(NR) && !RO[m_addr]) m_regs[m_addr] = d;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        a_astb = 1'b1;
        a_dstb = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (!a_wait) break;
        end
        check("wait_fall_lat", n, SS + 1);
        check("oe_after_release", a_db_oe, 0);
        if (!is_addr) m_addr = m_addr + 8'd1;
        check("addr_reg", addr_reg, m_addr);
        check("regs", regs_o, m_flat());
        check("wr_pulses", wr_cnt - w0, (!is_addr && is_wr) ? 1 : 0);
        check("rd_pulses", rd_cnt - r0, (!is_addr && !is_wr) ? 1 : 0);
        if (!is_addr) check("acc_addr", mon_acc, a_before);
        if (!is_addr && is_wr) check("wr_data", mon_wd, d);
    endtask

    initial begin
        int n;
        logic [7:0] d, a;
        rst = 1'b1; a_astb = 1'b1; a_dstb = 1'b1; a_write = 1'b1; a_db_i = '0;
        status_in = {$urandom, $urandom, $urandom, $urandom};
        status_in[5*8 +: 8] = 8'h5C;
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
        m_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_wait", a_wait, 0);
        check("rst_oe", a_db_oe, 0);
        check("rst_dbo", a_db_o, 0);
        check("rst_addr", addr_reg, 0);
        check("rst_regs", regs_o, 0);
        check("rst_stb", {wr_stb, rd_stb}, 0);

        host(1, 1, 8'h03, 0);
        host(0, 1, 8'hA5, 0);
        host(1, 1, 8'h03, 0);
        host(0, 0, 8'h00, 0);
        host(1, 0, 8'h00, 0);
        host(1, 1, 8'h05, 0);
        host(0, 1, 8'hFF, 0);
        host(1, 1, 8'h05, 0);
        host(0, 0, 8'h00, 0);
        host(1, 1, 8'hF0, 0);
        host(0, 0, 8'h00, 0);
        host(1, 1, 8'hFF, 0);
        host(0, 1, 8'h11, 0);
        host(0, 1, 8'h22, 0);
        check("wrap_reg0", regs_o[7:0], 8'h22);
        check("wrap_addr", addr_reg, 8'h01);

        // Reset while acknowledging a data read
        host(1, 1, 8'h03, 0);
        @(negedge clk);
        a_write = 1'b1;
        a_dstb  = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (a_wait) break;
        end
        check("abort_reach_ack", a_wait, 1);
        @(negedge clk);
        rst = 1'b1;
        a_dstb = 1'b1;
        @(posedge clk); #1;
        check("abort_wait", a_wait, 0);
        check("abort_oe", a_db_oe, 0);
        check("abort_addr", addr_reg, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
        m_addr = '0;
        n = 0;
        repeat (6) begin @(posedge clk); #1; if (a_wait) n++; end
        check("abort_idle", n, 0);
        host(0, 1, 8'h77, 0);
        host(1, 1, 8'h00, 0);
        host(0, 0, 8'h00, 0);

        // Random traffic, with a_write disturbed during the acknowledge phase
        for (int t = 0; t < 60; t++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 19));
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: host(1, 1, a, 1'($urandom_range(0, 1)));
                1: host(1, 0, d, 1'($urandom_range(0, 1)));
                2: host(0, 1, d, 1'($urandom_range(0, 1)));
                default: host(0, 0, d, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
